// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bullet_pkg
// Purpose  : Shared FSM states, color codes and slot record for bullet_pool.
// Revision : 1.0 - initial release
// ============================================================================
package bullet_pkg;

    // Slot fields are sized for the widest supported build; narrower builds zero-extend.
    localparam int SLOT_COORD_W = 16;
    localparam int SLOT_VEL_W   = 8;

    localparam logic [1:0] C_COLOR_WHITE = 2'd0;
    localparam logic [1:0] C_COLOR_GREEN = 2'd1;
    localparam logic [1:0] C_COLOR_BLUE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [SLOT_COORD_W-1:0] x;
        logic [SLOT_COORD_W-1:0] y;
        logic [SLOT_COORD_W-1:0] w;
        logic [SLOT_COORD_W-1:0] h;
        logic [1:0]              color;
        logic [SLOT_VEL_W-1:0]   vel;
        logic                    alive;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/bullet_pool_if.sv
`default_nettype none
// ============================================================================
// Interface : bullet_pool_if
// Purpose   : Control, spawn, kill and dual read channels of the bullet pool.
// Revision  : 1.0 - initial release
// ============================================================================
interface bullet_pool_if #(
    parameter int NUM_BULLETS = 8,
    parameter int COORD_W     = 8,
    parameter int VEL_W       = 3
);
    localparam int IDX_W = $clog2(NUM_BULLETS);

    logic                   run;
    logic                   tick;
    logic                   spawn_valid;
    logic                   spawn_ready;
    logic [COORD_W-1:0]     spawn_x;
    logic [COORD_W-1:0]     spawn_y;
    logic [COORD_W-1:0]     spawn_w;
    logic [COORD_W-1:0]     spawn_h;
    logic [1:0]             spawn_color;
    logic [VEL_W-1:0]       spawn_vel;
    logic [NUM_BULLETS-1:0] kill_mask;
    logic [IDX_W-1:0]       rd_idx_a;
    logic [IDX_W-1:0]       rd_idx_b;
    logic [2*COORD_W-1:0]   rd_pos_a;
    logic [2*COORD_W-1:0]   rd_pos_b;
    logic [2*COORD_W-1:0]   rd_size_a;
    logic [2*COORD_W-1:0]   rd_size_b;
    logic [1:0]             rd_color_a;
    logic [1:0]             rd_color_b;
    logic                   rd_alive_a;
    logic                   rd_alive_b;
    logic [IDX_W:0]         alive_count;

    modport master (
        output run, tick, spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
               spawn_color, spawn_vel, kill_mask, rd_idx_a, rd_idx_b,
        input  spawn_ready, rd_pos_a, rd_pos_b, rd_size_a, rd_size_b,
               rd_color_a, rd_color_b, rd_alive_a, rd_alive_b, alive_count
    );

    modport slave (
        input  run, tick, spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h,
               spawn_color, spawn_vel, kill_mask, rd_idx_a, rd_idx_b,
        output spawn_ready, rd_pos_a, rd_pos_b, rd_size_a, rd_size_b,
               rd_color_a, rd_color_b, rd_alive_a, rd_alive_b, alive_count
    );

endinterface
`default_nettype wire

// File: rtl/bullet_alloc.sv
`default_nettype none
// ============================================================================
// Module   : bullet_alloc
// Purpose  : Lowest-index-zero priority encoder used to pick a free slot.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_alloc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     busy,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the last hit is the lowest free index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool
// Purpose  : Fixed pool of bullet slots with spawn, per-tick motion, kill and
//            dual zero-latency read ports. Wrap-around: BULLET_POOL_WRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 8,
    parameter int COORD_W     = 8,
    parameter int VEL_W       = 3,
    parameter int Y_MAX       = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    bullet_pool_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_BULLETS);
    localparam int CNT_W = IDX_W + 1;
    localparam int SUM_W = SLOT_COORD_W + 1;

    state_t                 r_state;
    state_t                 w_state_next;
    slot_t                  w_slot [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] w_alive;
    logic [CNT_W-1:0]       r_alive_count;
    logic                   w_found;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_ready;
    logic                   w_spawn_fire;
    slot_t                  w_sel_a;
    slot_t                  w_sel_b;

    bullet_alloc #(
        .N     (NUM_BULLETS),
        .IDX_W (IDX_W)
    ) u_alloc (
        .busy  (w_alive),
        .found (w_found),
        .idx   (w_free_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        unique case (r_state)
            ST_IDLE:  if (bus.run) w_state_next = ST_RUN;
            ST_RUN: begin
                w_ready = w_found;
                if (!bus.run) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_spawn_fire = bus.spawn_valid && w_ready;

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        slot_t            r_slot;
        logic [SUM_W-1:0] w_y_next;
        logic             w_oob;

        // Wide sum keeps the carry so overflow past the field still counts as out of bounds.
        assign w_y_next = {1'b0, r_slot.y} + SUM_W'(r_slot.vel);
        assign w_oob    = (w_y_next >= SUM_W'(Y_MAX));
        assign w_slot[i]  = r_slot;
        assign w_alive[i] = r_slot.alive;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot <= '0;
            end else if (r_state == ST_FLUSH) begin
                r_slot.alive <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (r_slot.alive && bus.kill_mask[i]) begin
                    r_slot.alive <= 1'b0;
                end else if (w_spawn_fire && (w_free_idx == IDX_W'(i))) begin
                    r_slot.x     <= SLOT_COORD_W'(bus.spawn_x);
                    r_slot.y     <= SLOT_COORD_W'(bus.spawn_y);
                    r_slot.w     <= SLOT_COORD_W'(bus.spawn_w);
                    r_slot.h     <= SLOT_COORD_W'(bus.spawn_h);
                    r_slot.color <= bus.spawn_color;
                    r_slot.vel   <= SLOT_VEL_W'(bus.spawn_vel);
                    r_slot.alive <= 1'b1;
                end else if (r_slot.alive && bus.tick) begin
                    if (w_oob) begin
`ifdef BULLET_POOL_WRAP_EN
                        r_slot.y <= SLOT_COORD_W'(1);
`else
                        r_slot.alive <= 1'b0;
`endif
                    end else begin
                        r_slot.y <= w_y_next[SLOT_COORD_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive_count <= '0;
        end else begin
            r_alive_count <= CNT_W'($countones(w_alive));
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        if (32'(bus.rd_idx_a) < NUM_BULLETS) w_sel_a = w_slot[bus.rd_idx_a];
        if (32'(bus.rd_idx_b) < NUM_BULLETS) w_sel_b = w_slot[bus.rd_idx_b];
    end

    assign bus.rd_pos_a    = {w_sel_a.x[COORD_W-1:0], w_sel_a.y[COORD_W-1:0]};
    assign bus.rd_size_a   = {w_sel_a.w[COORD_W-1:0], w_sel_a.h[COORD_W-1:0]};
    assign bus.rd_color_a  = w_sel_a.color;
    assign bus.rd_alive_a  = w_sel_a.alive;
    assign bus.rd_pos_b    = {w_sel_b.x[COORD_W-1:0], w_sel_b.y[COORD_W-1:0]};
    assign bus.rd_size_b   = {w_sel_b.w[COORD_W-1:0], w_sel_b.h[COORD_W-1:0]};
    assign bus.rd_color_b  = w_sel_b.color;
    assign bus.rd_alive_b  = w_sel_b.alive;
    assign bus.spawn_ready = w_ready;
    assign bus.alive_count = r_alive_count;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bullet_pool
// Purpose  : Directed self-checking bench for bullet_pool.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_pool;

    localparam int NB    = 8;
    localparam int CW    = 8;
    localparam int VW    = 3;
    localparam int IDX_W = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bullet_pool_if #(.NUM_BULLETS(NB), .COORD_W(CW), .VEL_W(VW)) bus ();

    bullet_pool #(
        .NUM_BULLETS (NB),
        .COORD_W     (CW),
        .VEL_W       (VW),
        .Y_MAX       (200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int idx);
        bus.rd_idx_a = IDX_W'(idx);
        bus.rd_idx_b = IDX_W'(idx);
        #1;
    endtask

    task automatic set_spawn(input int x, input int y, input int w, input int h,
                             input int color, input int vel);
        bus.spawn_x     = CW'(x);
        bus.spawn_y     = CW'(y);
        bus.spawn_w     = CW'(w);
        bus.spawn_h     = CW'(h);
        bus.spawn_color = 2'(color);
        bus.spawn_vel   = VW'(vel);
    endtask

    function automatic logic [31:0] pos(input int x, input int y);
        return 32'((x << 8) | y);
    endfunction

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        clk             = 1'b0;
        rst_n           = 1'b0;
        bus.run         = 1'b0;
        bus.tick        = 1'b0;
        bus.spawn_valid = 1'b0;
        bus.kill_mask   = '0;
        bus.rd_idx_a    = '0;
        bus.rd_idx_b    = '0;
        set_spawn(0, 0, 0, 0, 0, 0);

        // Reset state
        #20;
        check("rst_ready", 32'(bus.spawn_ready), 0);
        check("rst_count", 32'(bus.alive_count), 0);
        check("rst_alive", 32'(bus.rd_alive_a), 0);
        check("rst_pos",   32'(bus.rd_pos_a), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.run = 1'b1;
        step();
        check("run_ready", 32'(bus.spawn_ready), 1);

        // Fill: eight back-to-back spawns
        for (int i = 0; i < NB; i++) begin
            set_spawn(16 + i, 20 + i, 4, 6, i % 3, 1);
            bus.spawn_valid = 1'b1;
            step();
        end
        bus.spawn_valid = 1'b0;
        check("fill_count_lag", 32'(bus.alive_count), 7);
        check("fill_ready", 32'(bus.spawn_ready), 0);
        step();
        check("fill_count", 32'(bus.alive_count), 8);
        for (int i = 0; i < NB; i++) begin
            peek(i);
            check($sformatf("fill_alive%0d", i), 32'(bus.rd_alive_a), 1);
            check($sformatf("fill_pos%0d", i), 32'(bus.rd_pos_a), pos(16 + i, 20 + i));
            check($sformatf("fill_size%0d", i), 32'(bus.rd_size_b), pos(4, 6));
            check($sformatf("fill_color%0d", i), 32'(bus.rd_color_b), 32'(i % 3));
        end

        // Collide: kill slots 0 and 2 with tick and a refused spawn in the same cycle
        set_spawn(50, 77, 2, 2, 2, 2);
        bus.spawn_valid = 1'b1;
        bus.kill_mask   = 8'b0000_0101;
        bus.tick        = 1'b1;
        check("col_ready_full", 32'(bus.spawn_ready), 0);
        step();
        bus.kill_mask = '0;
        bus.tick      = 1'b0;
        check("col_ready_after", 32'(bus.spawn_ready), 1);
        check("col_count_lag", 32'(bus.alive_count), 8);
        peek(0); check("col_alive0", 32'(bus.rd_alive_a), 0);
                 check("col_pos0", 32'(bus.rd_pos_a), pos(16, 20));
        peek(2); check("col_alive2", 32'(bus.rd_alive_b), 0);
        peek(1); check("col_pos1", 32'(bus.rd_pos_a), pos(17, 22));
        peek(7); check("col_pos7", 32'(bus.rd_pos_b), pos(23, 28));
        step();
        bus.spawn_valid = 1'b0;
        check("col_count_drop", 32'(bus.alive_count), 6);
        peek(0); check("col_respawn_alive", 32'(bus.rd_alive_a), 1);
                 check("col_respawn_pos", 32'(bus.rd_pos_a), pos(50, 77));
                 check("col_respawn_color", 32'(bus.rd_color_a), 2);
        peek(2); check("col_slot2_dead", 32'(bus.rd_alive_a), 0);
        step();
        check("col_count_after", 32'(bus.alive_count), 7);

        // Flush: inputs other than run are ignored in FLUSH and IDLE
        bus.run = 1'b0;
        step();
        check("flush_ready", 32'(bus.spawn_ready), 0);
        bus.spawn_valid = 1'b1;
        bus.kill_mask   = '1;
        bus.tick        = 1'b1;
        set_spawn(99, 99, 9, 9, 1, 7);
        step();
        for (int i = 0; i < NB; i++) begin
            peek(i);
            check($sformatf("flush_alive%0d", i), 32'(bus.rd_alive_a), 0);
        end
        step();
        check("idle_count", 32'(bus.alive_count), 0);
        check("idle_ready", 32'(bus.spawn_ready), 0);
        peek(1); check("idle_pos1_kept", 32'(bus.rd_pos_a), pos(17, 22));
        peek(0); check("idle_no_spawn", 32'(bus.rd_pos_a), pos(50, 77));
        bus.spawn_valid = 1'b0;
        bus.kill_mask   = '0;
        bus.tick        = 1'b0;

        // Move: y=10 vel=5 over three ticks
        bus.run = 1'b1;
        step();
        set_spawn(3, 10, 1, 1, 1, 5);
        bus.spawn_valid = 1'b1;
        step();
        bus.spawn_valid = 1'b0;
        bus.tick        = 1'b1;
        step(); step(); step();
        bus.tick = 1'b0;
        peek(0); check("move_pos", 32'(bus.rd_pos_a), pos(3, 25));
        step(); step();
        peek(0); check("move_hold", 32'(bus.rd_pos_a), pos(3, 25));

        // Bounds: 198+3 and 195+5 leave, 197+2 stays
        bus.spawn_valid = 1'b1;
        set_spawn(1, 198, 1, 1, 0, 3); step();
        set_spawn(2, 197, 1, 1, 0, 2); step();
        set_spawn(4, 195, 1, 1, 0, 5); step();
        bus.spawn_valid = 1'b0;
        bus.tick        = 1'b1;
        step();
        bus.tick = 1'b0;
        peek(0); check("bnd_pos0", 32'(bus.rd_pos_a), pos(3, 30));
        peek(2); check("bnd_alive2", 32'(bus.rd_alive_a), 1);
                 check("bnd_pos2", 32'(bus.rd_pos_a), pos(2, 199));
`ifdef BULLET_POOL_WRAP_EN
        peek(1); check("bnd_alive1", 32'(bus.rd_alive_a), 1);
                 check("bnd_pos1", 32'(bus.rd_pos_a), pos(1, 1));
        peek(3); check("bnd_alive3", 32'(bus.rd_alive_a), 1);
                 check("bnd_pos3", 32'(bus.rd_pos_a), pos(4, 1));
`else
        peek(1); check("bnd_alive1", 32'(bus.rd_alive_a), 0);
                 check("bnd_pos1", 32'(bus.rd_pos_a), pos(1, 198));
        peek(3); check("bnd_alive3", 32'(bus.rd_alive_a), 0);
                 check("bnd_pos3", 32'(bus.rd_pos_a), pos(4, 195));
`endif

        // Async reset between edges with a spawn pending
        set_spawn(99, 99, 9, 9, 1, 1);
        bus.spawn_valid = 1'b1;
        #20;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.spawn_ready), 0);
        check("arst_count", 32'(bus.alive_count), 0);
        peek(0); check("arst_alive0", 32'(bus.rd_alive_a), 0);
                 check("arst_pos0", 32'(bus.rd_pos_a), 0);
        step();
        peek(1); check("arst_pos1", 32'(bus.rd_pos_a), 0);
        peek(4); check("arst_pos4", 32'(bus.rd_pos_b), 0);
        @(negedge clk);
        bus.spawn_valid = 1'b0;
        bus.run         = 1'b0;
        rst_n           = 1'b1;
        step();
        check("arst_count_after", 32'(bus.alive_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
